// File: rtl/debug_dmi_responder_if.sv
// DMI responder signal bundle: request CDC read port, response CDC write
// port and the Debug Module register bus. The responder uses the slave
// modport; whatever surrounds it (CDC channels, bus, testbench) uses master.
interface debug_dmi_responder_if #(
  parameter int ABITS = 7
);
  logic              REQ_RDY;
  logic [ABITS+33:0] REQ_DATA;
  logic              REQ_GET;
  logic              RSP_RDY;
  logic              RSP_PUT;
  logic [33:0]       RSP_DATA;
  logic              DMI_REQ;
  logic              DMI_WRITE;
  logic [ABITS-1:0]  DMI_ADDR;
  logic [31:0]       DMI_WDATA;
  logic              DMI_ACK;
  logic [31:0]       DMI_RDATA;
  logic              DMI_ERR;

  modport master (
    output REQ_RDY, REQ_DATA, RSP_RDY, DMI_ACK, DMI_RDATA, DMI_ERR,
    input  REQ_GET, RSP_PUT, RSP_DATA, DMI_REQ, DMI_WRITE, DMI_ADDR, DMI_WDATA
  );

  modport slave (
    input  REQ_RDY, REQ_DATA, RSP_RDY, DMI_ACK, DMI_RDATA, DMI_ERR,
    output REQ_GET, RSP_PUT, RSP_DATA, DMI_REQ, DMI_WRITE, DMI_ADDR, DMI_WDATA
  );
endinterface

// File: rtl/debug_dmi_responder.sv
// System-clock end of the DMI path. Pops one request from the request CDC,
// runs it on the Debug Module register bus, pushes the response back.
// Only one transaction is ever in flight, matching the 1-deep CDC channels.
//
// state | meaning
// IDLE  | waiting for a request; REQ_GET follows REQ_RDY
// BUS   | DMI_REQ held until DMI_ACK or bus timeout
// RESP  | RSP_PUT held with registered RSP_DATA until RSP_RDY
module debug_dmi_responder #(
  parameter int ABITS   = 7,
  parameter int TIMEOUT = 256
) (
  input  logic                  CLK,
  input  logic                  RES_N,
  debug_dmi_responder_if.slave  dmi,
  output logic                  BUSY
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_MAX  = '1;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  localparam logic [1:0] RESP_OK   = 2'd0;
  localparam logic [1:0] RESP_FAIL = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [ABITS-1:0] addr_q;
  logic [31:0]      wdata_q;
  logic             dmi_req_q;
  logic             rsp_put_q;
  logic [33:0]      rsp_data_q;
  logic [TW-1:0]    timer;

  logic [ABITS-1:0] req_addr;
  logic [31:0]      req_wdata;
  logic [1:0]       req_op;

  assign req_addr  = dmi.REQ_DATA[ABITS+33:34];
  assign req_wdata = dmi.REQ_DATA[33:2];
  assign req_op    = dmi.REQ_DATA[1:0];

  // Pop only from IDLE; gated by reset so nothing is consumed while held in reset.
  assign dmi.REQ_GET   = (state == ST_IDLE) && dmi.REQ_RDY && RES_N;
  assign dmi.DMI_REQ   = dmi_req_q;
  assign dmi.DMI_WRITE = (op_q == OP_WRITE);
  assign dmi.DMI_ADDR  = addr_q;
  assign dmi.DMI_WDATA = wdata_q;
  assign dmi.RSP_PUT   = rsp_put_q;
  assign dmi.RSP_DATA  = rsp_data_q;
  assign BUSY          = (state != ST_IDLE);

  // Transaction sequencer: latch request, drive bus, hold response until taken.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      state      <= ST_IDLE;
      op_q       <= OP_NOP;
      addr_q     <= '0;
      wdata_q    <= '0;
      dmi_req_q  <= 1'b0;
      rsp_put_q  <= 1'b0;
      rsp_data_q <= '0;
      timer      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dmi.REQ_RDY) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            timer   <= '0;
            case (req_op)
              OP_READ, OP_WRITE: begin
                dmi_req_q <= 1'b1;
                state     <= ST_BUS;
              end
              OP_NOP: begin
                rsp_data_q <= {32'h0, RESP_OK};
                rsp_put_q  <= 1'b1;
                state      <= ST_RESP;
              end
              default: begin
                rsp_data_q <= {32'h0, RESP_FAIL};
                rsp_put_q  <= 1'b1;
                state      <= ST_RESP;
              end
            endcase
          end
        end
        ST_BUS: begin
          // An ack on the timeout cycle still wins and gives a normal response.
          if (dmi.DMI_ACK) begin
            dmi_req_q  <= 1'b0;
            rsp_data_q <= {(op_q == OP_READ) ? dmi.DMI_RDATA : 32'h0,
                           dmi.DMI_ERR ? RESP_FAIL : RESP_OK};
            rsp_put_q  <= 1'b1;
            state      <= ST_RESP;
          end else if ((TIMEOUT != 0) && (timer == TIMER_LAST)) begin
            dmi_req_q  <= 1'b0;
            rsp_data_q <= {32'h0, RESP_FAIL};
            rsp_put_q  <= 1'b1;
            state      <= ST_RESP;
          end else if (timer != TIMER_MAX) begin
            timer <= timer + 1'b1;
          end
        end
        ST_RESP: begin
          if (dmi.RSP_RDY) begin
            rsp_put_q <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_dmi_responder.sv
// Bench for debug_dmi_responder: a table of directed transactions, a reset
// abort sequence, then randomized transactions predicted by a simple
// per-transaction model (response word, bus-request cycles, latency).
module tb_debug_dmi_responder;

  localparam int ABITS   = 7;
  localparam int TIMEOUT = 8;

  logic CLK;
  logic RES_N;
  logic BUSY;

  debug_dmi_responder_if #(.ABITS(ABITS)) dif ();

  debug_dmi_responder #(.ABITS(ABITS), .TIMEOUT(TIMEOUT)) dut (
    .CLK   (CLK),
    .RES_N (RES_N),
    .dmi   (dif),
    .BUSY  (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]       op;
    logic [ABITS-1:0] addr;
    logic [31:0]      data;
    int               k;      // bus cycle on which ack is given, 0 = never
    logic [31:0]      rdata;
    logic             err;
    int               stall;  // cycles RSP_RDY held low once RSP_PUT rises
    logic             pend;   // next request already waiting during the response
    logic [33:0]      rsp;
    int               high;   // expected DMI_REQ high cycles
    int               lat;    // expected cycles from REQ_GET to RSP_PUT
  } txn_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  // Reference: what a single transaction must produce, from the op/ack rules.
  function automatic txn_t predict(input txn_t t);
    txn_t r;
    r = t;
    if (t.op == 2'd0) begin
      r.rsp = {32'h0, 2'd0}; r.high = 0; r.lat = 1;
    end else if (t.op == 2'd3) begin
      r.rsp = {32'h0, 2'd2}; r.high = 0; r.lat = 1;
    end else if (t.k >= 1 && t.k <= TIMEOUT) begin
      r.rsp  = {(t.op == 2'd1) ? t.rdata : 32'h0, t.err ? 2'd2 : 2'd0};
      r.high = t.k;
      r.lat  = t.k + 1;
    end else begin
      r.rsp  = {32'h0, 2'd2};
      r.high = TIMEOUT;
      r.lat  = TIMEOUT + 1;
    end
    return r;
  endfunction

  task automatic run_txn(input txn_t t);
    int w;
    int hi;
    int lat;
    logic seen_put;
    logic [33:0] held;
    dif.REQ_DATA = {t.addr, t.data, t.op};
    dif.REQ_RDY  = 1'b1;
    dif.DMI_ACK  = 1'b0;
    dif.RSP_RDY  = (t.stall == 0);
    #1;
    w = 0;
    while (!dif.REQ_GET && w < 20) begin
      tick();
      w++;
    end
    check("req_get_pop", dif.REQ_GET, 1'b1);
    if (dif.REQ_GET !== 1'b1) begin
      dif.REQ_RDY = 1'b0;
      return;
    end
    dif.DMI_ACK   = 1'($urandom_range(0, 1));
    dif.DMI_RDATA = $urandom;
    dif.DMI_ERR   = 1'($urandom_range(0, 1));
    hi = 0;
    lat = 0;
    seen_put = 1'b0;
    for (int c = 1; c <= TIMEOUT + 6 && !seen_put; c++) begin
      tick();
      if (c == 1) dif.REQ_RDY = t.pend;
      check("req_get_busy", dif.REQ_GET, 1'b0);
      if (dif.DMI_REQ === 1'b1) begin
        hi++;
        check("dmi_write", dif.DMI_WRITE, (t.op == 2'd2));
        check("dmi_addr", dif.DMI_ADDR, t.addr);
        check("dmi_wdata", dif.DMI_WDATA, t.data);
        dif.DMI_ACK   = (hi == t.k);
        dif.DMI_RDATA = (hi == t.k) ? t.rdata : $urandom;
        dif.DMI_ERR   = (hi == t.k) ? t.err : 1'($urandom_range(0, 1));
      end else begin
        // Ack outside the bus phase must be ignored.
        dif.DMI_ACK   = 1'($urandom_range(0, 1));
        dif.DMI_RDATA = $urandom;
        dif.DMI_ERR   = 1'($urandom_range(0, 1));
      end
      if (dif.RSP_PUT === 1'b1) begin
        seen_put = 1'b1;
        lat = c;
      end
    end
    check("rsp_latency", lat, t.lat);
    check("dmi_req_cycles", hi, t.high);
    check("rsp_data", dif.RSP_DATA, t.rsp);
    check("busy_in_resp", BUSY, 1'b1);
    if (seen_put) begin
      held = dif.RSP_DATA;
      for (int s = 0; s < t.stall; s++) begin
        tick();
        check("stall_put", dif.RSP_PUT, 1'b1);
        check("stall_data", dif.RSP_DATA, held);
        check("stall_req_get", dif.REQ_GET, 1'b0);
      end
      dif.RSP_RDY = 1'b1;
      tick();
      check("put_drop", dif.RSP_PUT, 1'b0);
      check("busy_idle", BUSY, 1'b0);
      check("rsp_data_kept", dif.RSP_DATA, t.rsp);
      check("repop_first_idle", dif.REQ_GET, t.pend);
    end
    dif.DMI_ACK = 1'b0;
    if (!t.pend) dif.REQ_RDY = 1'b0;
  endtask

  txn_t tbl [10];
  txn_t r;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    //           op     addr   data           k  rdata          err   stall pend  rsp                          high lat
    tbl[0] = '{2'd2, 7'h10, 32'hDEADBEEF, 3, 32'hAAAA5555, 1'b0, 0,  1'b0, {32'h0, 2'd0},             3, 4};
    tbl[1] = '{2'd1, 7'h11, 32'h00000000, 1, 32'h12345678, 1'b0, 0,  1'b0, {32'h12345678, 2'd0},      1, 2};
    tbl[2] = '{2'd0, 7'h05, 32'h00001111, 0, 32'h0,        1'b0, 0,  1'b0, {32'h0, 2'd0},             0, 1};
    tbl[3] = '{2'd3, 7'h06, 32'h00002222, 0, 32'h0,        1'b0, 0,  1'b0, {32'h0, 2'd2},             0, 1};
    tbl[4] = '{2'd1, 7'h20, 32'h0,        0, 32'h0,        1'b0, 0,  1'b0, {32'h0, 2'd2},             8, 9};
    tbl[5] = '{2'd1, 7'h21, 32'h0,        8, 32'hCAFEF00D, 1'b0, 0,  1'b0, {32'hCAFEF00D, 2'd0},      8, 9};
    tbl[6] = '{2'd2, 7'h30, 32'h01020304, 2, 32'h0,        1'b1, 0,  1'b0, {32'h0, 2'd2},             2, 3};
    tbl[7] = '{2'd1, 7'h31, 32'h0,        5, 32'hFFFFFFFF, 1'b1, 2,  1'b0, {32'hFFFFFFFF, 2'd2},      5, 6};
    tbl[8] = '{2'd1, 7'h40, 32'h0,        2, 32'h0BADF00D, 1'b0, 20, 1'b1, {32'h0BADF00D, 2'd0},      2, 3};
    tbl[9] = '{2'd2, 7'h7F, 32'h5A5A5A5A, 1, 32'h0,        1'b0, 0,  1'b0, {32'h0, 2'd0},             1, 2};

    RES_N         = 1'b0;
    dif.REQ_RDY   = 1'b1;
    dif.REQ_DATA  = '0;
    dif.RSP_RDY   = 1'b1;
    dif.DMI_ACK   = 1'b1;
    dif.DMI_RDATA = 32'hFFFFFFFF;
    dif.DMI_ERR   = 1'b1;
    tick();
    tick();
    check("rst_req_get", dif.REQ_GET, 1'b0);
    check("rst_rsp_put", dif.RSP_PUT, 1'b0);
    check("rst_rsp_data", dif.RSP_DATA, 34'h0);
    check("rst_dmi_req", dif.DMI_REQ, 1'b0);
    check("rst_dmi_write", dif.DMI_WRITE, 1'b0);
    check("rst_dmi_addr", dif.DMI_ADDR, 7'h0);
    check("rst_dmi_wdata", dif.DMI_WDATA, 32'h0);
    check("rst_busy", BUSY, 1'b0);
    dif.REQ_RDY = 1'b0;
    dif.DMI_ACK = 1'b0;
    RES_N = 1'b1;
    tick();
    tick();
    check("idle_busy", BUSY, 1'b0);

    for (int i = 0; i < 10; i++) run_txn(tbl[i]);

    // Reset while a read waits on the bus: abandon it with no response.
    dif.REQ_DATA = {7'h22, 32'h0, 2'd1};
    dif.REQ_RDY  = 1'b1;
    dif.RSP_RDY  = 1'b1;
    #1;
    check("abort_pop", dif.REQ_GET, 1'b1);
    tick();
    dif.REQ_RDY = 1'b0;
    tick();
    tick();
    check("abort_in_bus", dif.DMI_REQ, 1'b1);
    check("abort_busy", BUSY, 1'b1);
    RES_N = 1'b0;
    #1;
    check("abort_dmi_req", dif.DMI_REQ, 1'b0);
    check("abort_rsp_put", dif.RSP_PUT, 1'b0);
    check("abort_busy_low", BUSY, 1'b0);
    check("abort_rsp_data", dif.RSP_DATA, 34'h0);
    tick();
    RES_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_put", dif.RSP_PUT, 1'b0);
      check("abort_no_req", dif.DMI_REQ, 1'b0);
    end
    r = '{2'd1, 7'h23, 32'h0, 4, 32'h87654321, 1'b0, 0, 1'b0, {32'h87654321, 2'd0}, 4, 5};
    run_txn(r);

    for (int i = 0; i < 40; i++) begin
      r.op    = 2'($urandom_range(0, 3));
      r.addr  = 7'($urandom);
      r.data  = $urandom;
      r.k     = $urandom_range(0, TIMEOUT + 2);
      r.rdata = $urandom;
      r.err   = 1'($urandom_range(0, 1));
      r.stall = $urandom_range(0, 3);
      r.pend  = 1'b0;
      r = predict(r);
      run_txn(r);
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
